// File: rtl/axi_rd_path_pkg.sv
// axi_rd_path_pkg -- AXI constants shared by the AXI4-to-SDRAM read datapath.
// Contents: burst-type and response enums, fixed burst geometry (4-beat INCR).
package axi_rd_path_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10
   } axi_burst_e;

   typedef enum logic [1:0] {
      AXI_RESP_OKAY   = 2'b00,
      AXI_RESP_EXOKAY = 2'b01,
      AXI_RESP_SLVERR = 2'b10,
      AXI_RESP_DECERR = 2'b11
   } axi_resp_e;

   // Only one burst shape is supported: 4 beats, so arlen is always 3.
   localparam int         BURST_BEATS = 4;
   localparam logic [7:0] BURST_LEN   = 8'(BURST_BEATS - 1);
   localparam logic [1:0] LAST_BEAT   = 2'(BURST_BEATS - 1);

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo -- single-clock first-word-fall-through FIFO.
// The head entry is visible on pop_data whenever empty=0; a pushed entry
// becomes visible one cycle after the push.
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   push, push_data     write strobe and data (ignored when full)
//   pop                 advance to next entry (ignored when empty)
//   pop_data            current head entry
//   empty, full, count  occupancy status
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    push,
   input  logic [WIDTH-1:0]        push_data,
   input  logic                    pop,
   output logic [WIDTH-1:0]        pop_data,
   output logic                    empty,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   // NOTE: storage has no reset; pointers and count alone define validity, so RAM can be inferred.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign pop_data = mem[rd_ptr];
   assign empty    = (count == '0);
   assign full     = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/axi_rd_path.sv
// axi_rd_path -- read datapath of the AXI4-to-SDRAM interface.
// AR requests are queued as fetch commands to the memory controller; returned
// beats are buffered and replayed on the R channel in issue order. A fetch is
// only issued once buffer space for the whole burst is reserved (credit), so
// the controller never sees mem_ready_o drop mid-burst.
// Ports:
//   clock, reset                       system clock, synchronous active-high reset
//   axi_ar{valid,ready,addr,id,len,burst}   AXI4 read-address channel
//   axi_r{valid,ready,last,resp,id,data}    AXI4 read-data channel
//   mem_fetch_o/mem_accept_i, mem_rdid_o, mem_addr_o   command to controller
//   mem_valid_i/mem_ready_o, mem_last_i, mem_data_i    read data from controller
module axi_rd_path
   import axi_rd_path_pkg::*;
#(
   parameter int ADDRS           = 32,
   parameter int WIDTH           = 32,
   parameter int AXI_ID_WIDTH    = 4,
   parameter int CTRL_FIFO_DEPTH = 16,
   parameter int DATA_FIFO_DEPTH = 512
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    axi_arvalid_i,
   output logic                    axi_arready_o,
   input  logic [ADDRS-1:0]        axi_araddr_i,
   input  logic [AXI_ID_WIDTH-1:0] axi_arid_i,
   input  logic [7:0]              axi_arlen_i,
   input  logic [1:0]              axi_arburst_i,
   output logic                    axi_rvalid_o,
   input  logic                    axi_rready_i,
   output logic                    axi_rlast_o,
   output logic [1:0]              axi_rresp_o,
   output logic [AXI_ID_WIDTH-1:0] axi_rid_o,
   output logic [WIDTH-1:0]        axi_rdata_o,
   output logic                    mem_fetch_o,
   input  logic                    mem_accept_i,
   output logic [AXI_ID_WIDTH-1:0] mem_rdid_o,
   output logic [ADDRS-1:0]        mem_addr_o,
   input  logic                    mem_valid_i,
   output logic                    mem_ready_o,
   input  logic                    mem_last_i,
   input  logic [WIDTH-1:0]        mem_data_i
);

   localparam int CW    = $clog2(DATA_FIFO_DEPTH) + 1;
   localparam int QW    = $clog2(CTRL_FIFO_DEPTH) + 1;
   localparam int CMD_W = ADDRS + AXI_ID_WIDTH;

   logic             ar_hs;
   logic             fetch_hs;
   logic             r_hs;
   logic             mem_hs;

   logic             cmd_empty;
   logic             cmd_full;
   logic [QW-1:0]    cmd_count;
   logic [QW-1:0]    cmd_free;
   logic [CMD_W-1:0] cmd_head;

   logic             tag_empty;
   logic             tag_full;
   logic [QW-1:0]    tag_count;

   logic             data_empty;
   logic             data_full;
   logic [CW-1:0]    data_count;

   logic             arready_q;
   logic [CW-1:0]    credit;
   logic [CW-1:0]    credit_next;
   logic             credit_ok;
   logic [1:0]       r_beat;

   assign ar_hs    = axi_arvalid_i && arready_q;
   assign fetch_hs = mem_fetch_o && mem_accept_i;
   assign r_hs     = axi_rvalid_o && axi_rready_i;
   assign mem_hs   = mem_valid_i && mem_ready_o;

   // ---------------- AR channel -> command FIFO ----------------
   sync_fifo #(.WIDTH(CMD_W), .DEPTH(CTRL_FIFO_DEPTH)) u_cmd_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (ar_hs),
      .push_data ({axi_araddr_i, axi_arid_i}),
      .pop       (fetch_hs),
      .pop_data  (cmd_head),
      .empty     (cmd_empty),
      .full      (cmd_full),
      .count     (cmd_count)
   );

   // arready is registered, so it must already guarantee room for a push
   // landing in the same cycle it was computed: keep one slot in hand.
   assign cmd_free = QW'(CTRL_FIFO_DEPTH) - cmd_count;

   always_ff @(posedge clock) begin
      if (reset) arready_q <= 1'b0;
      else       arready_q <= (cmd_free >= QW'(2)) || ((cmd_free >= QW'(1)) && !ar_hs);
   end

   assign axi_arready_o = arready_q;

   // ---------------- Issue to the memory controller ----------------
   // credit counts data-buffer beats reserved by issued fetches and not yet
   // returned on R. Extended by one bit so the room check cannot wrap.
   assign credit_ok = ({1'b0, credit} + (CW+1)'(BURST_BEATS)) <= (CW+1)'(DATA_FIFO_DEPTH);

   // Once asserted, fetch stays up with the same head: nothing but accept
   // pops the command FIFO, and credit/tag occupancy only move toward room.
   assign mem_fetch_o             = !cmd_empty && !tag_full && credit_ok;
   assign {mem_addr_o, mem_rdid_o} = cmd_head;

   // NOTE: combinational blocks assign every output a default first so no latch is inferred.
   always_comb begin
      credit_next = credit;
      if (fetch_hs) credit_next = credit_next + CW'(BURST_BEATS);
      if (r_hs)     credit_next = credit_next - CW'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) credit <= '0;
      else       credit <= credit_next;
   end

   // In-flight IDs, in issue order; popped when the burst's last beat leaves.
   sync_fifo #(.WIDTH(AXI_ID_WIDTH), .DEPTH(CTRL_FIFO_DEPTH)) u_tag_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (fetch_hs),
      .push_data (mem_rdid_o),
      .pop       (r_hs && axi_rlast_o),
      .pop_data  (axi_rid_o),
      .empty     (tag_empty),
      .full      (tag_full),
      .count     (tag_count)
   );

   // ---------------- Read data buffer -> R channel ----------------
   sync_fifo #(.WIDTH(WIDTH), .DEPTH(DATA_FIFO_DEPTH)) u_data_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (mem_hs),
      .push_data (mem_data_i),
      .pop       (r_hs),
      .pop_data  (axi_rdata_o),
      .empty     (data_empty),
      .full      (data_full),
      .count     (data_count)
   );

   assign mem_ready_o  = !reset && !data_full;
   assign axi_rvalid_o = !data_empty;
   assign axi_rresp_o  = AXI_RESP_OKAY;

   // Output-side beat position within the current burst; wraps 3 -> 0.
   always_ff @(posedge clock) begin
      if (reset)     r_beat <= '0;
      else if (r_hs) r_beat <= r_beat + 2'd1;
   end

   assign axi_rlast_o = (r_beat == LAST_BEAT);

   // ---------------- Simulation-only protocol checks ----------------
`ifndef SYNTHESIS
   logic [1:0] in_beat;

   always_ff @(posedge clock) begin
      if (reset)       in_beat <= '0;
      else if (mem_hs) in_beat <= in_beat + 2'd1;
   end

   always @(posedge clock) begin
      if (!reset) begin
         if (axi_arvalid_i)
            assert (axi_arburst_i == BURST_INCR && axi_arlen_i == BURST_LEN && axi_araddr_i[6:0] == 7'd0)
            else $error("axi_rd_path: unsupported AR addr=%h len=%0d burst=%b",
                        axi_araddr_i, axi_arlen_i, axi_arburst_i);
         assert (!(ar_hs && cmd_full))
            else $fatal(1, "axi_rd_path: AR accepted into a full command FIFO");
         assert (!(mem_valid_i && data_full))
            else $fatal(1, "axi_rd_path: read beat offered while data buffer full");
         assert (!(axi_rvalid_o && tag_empty))
            else $fatal(1, "axi_rd_path: R data present with no in-flight ID");
         if (mem_hs)
            assert (mem_last_i == (in_beat == LAST_BEAT))
            else $fatal(1, "axi_rd_path: mem_last_i at beat %0d", in_beat);
         assert (credit >= data_count)
            else $fatal(1, "axi_rd_path: buffered beats exceed credit");
         assert (int'(credit) == BURST_BEATS * int'(tag_count) - int'(r_beat))
            else $fatal(1, "axi_rd_path: credit %0d inconsistent with tags %0d", credit, tag_count);
      end
   end
`endif

endmodule

// File: tb/tb_axi_rd_path.sv
// tb_axi_rd_path -- directed, scoreboard-based bench for axi_rd_path.
// Background processes play the AR master, the memory controller and the R
// sink; the main initial block sequences the scenarios. Inputs change on the
// falling edge, outputs are sampled 1 time unit later.
module tb_axi_rd_path;
   import axi_rd_path_pkg::*;

   localparam int ADDRS = 32;
   localparam int WIDTH = 32;
   localparam int IDW   = 4;
   localparam int CTRL  = 16;
   localparam int DDEP  = 8;

   typedef struct {
      logic [IDW-1:0]   id;
      logic [ADDRS-1:0] addr;
   } cmd_t;

   typedef struct {
      logic [IDW-1:0]   id;
      logic [WIDTH-1:0] data;
      logic             last;
   } beat_t;

   typedef struct {
      logic [WIDTH-1:0] data;
      logic             last;
   } ret_t;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             axi_arvalid_i = 1'b0;
   logic             axi_arready_o;
   logic [ADDRS-1:0] axi_araddr_i = '0;
   logic [IDW-1:0]   axi_arid_i = '0;
   logic [7:0]       axi_arlen_i = 8'd3;
   logic [1:0]       axi_arburst_i = 2'b01;
   logic             axi_rvalid_o;
   logic             axi_rready_i = 1'b0;
   logic             axi_rlast_o;
   logic [1:0]       axi_rresp_o;
   logic [IDW-1:0]   axi_rid_o;
   logic [WIDTH-1:0] axi_rdata_o;
   logic             mem_fetch_o;
   logic             mem_accept_i = 1'b0;
   logic [IDW-1:0]   mem_rdid_o;
   logic [ADDRS-1:0] mem_addr_o;
   logic             mem_valid_i = 1'b0;
   logic             mem_ready_o;
   logic             mem_last_i = 1'b0;
   logic [WIDTH-1:0] mem_data_i = '0;

   int n_checks = 0;
   int n_fail   = 0;
   int ar_count = 0;
   int acc_count = 0;
   int r_beats  = 0;

   logic accept_en = 1'b1;
   logic rready_en = 1'b1;

   cmd_t  ar_pend[$];
   cmd_t  exp_cmd_q[$];
   beat_t exp_r_q[$];
   ret_t  ret_q[$];

   always #5 clock = ~clock;

   axi_rd_path #(
      .ADDRS(ADDRS), .WIDTH(WIDTH), .AXI_ID_WIDTH(IDW),
      .CTRL_FIFO_DEPTH(CTRL), .DATA_FIFO_DEPTH(DDEP)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .axi_arvalid_i (axi_arvalid_i),
      .axi_arready_o (axi_arready_o),
      .axi_araddr_i  (axi_araddr_i),
      .axi_arid_i    (axi_arid_i),
      .axi_arlen_i   (axi_arlen_i),
      .axi_arburst_i (axi_arburst_i),
      .axi_rvalid_o  (axi_rvalid_o),
      .axi_rready_i  (axi_rready_i),
      .axi_rlast_o   (axi_rlast_o),
      .axi_rresp_o   (axi_rresp_o),
      .axi_rid_o     (axi_rid_o),
      .axi_rdata_o   (axi_rdata_o),
      .mem_fetch_o   (mem_fetch_o),
      .mem_accept_i  (mem_accept_i),
      .mem_rdid_o    (mem_rdid_o),
      .mem_addr_o    (mem_addr_o),
      .mem_valid_i   (mem_valid_i),
      .mem_ready_o   (mem_ready_o),
      .mem_last_i    (mem_last_i),
      .mem_data_i    (mem_data_i)
   );

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Expected data of a burst: address + 0x20 + beat index (0x80 -> A0..A3).
   function automatic logic [WIDTH-1:0] beat_data(input logic [ADDRS-1:0] addr, input int k);
      return addr + 32'h20 + 32'(k);
   endfunction

   // AR master: presents the head of ar_pend; on handshake records the
   // expected command and the four expected R beats.
   initial begin : ar_master
      cmd_t c;
      forever begin
         @(negedge clock);
         if (!reset && ar_pend.size() > 0) begin
            axi_arvalid_i = 1'b1;
            axi_araddr_i  = ar_pend[0].addr;
            axi_arid_i    = ar_pend[0].id;
         end else begin
            axi_arvalid_i = 1'b0;
         end
         #1;
         if (!reset && axi_arvalid_i && axi_arready_o) begin
            c = ar_pend.pop_front();
            exp_cmd_q.push_back(c);
            for (int k = 0; k < 4; k++)
               exp_r_q.push_back('{id: c.id, data: beat_data(c.addr, k), last: (k == 3)});
            ar_count++;
         end
      end
   end

   // Memory controller model: accepts when accept_en, returns 4 beats per
   // accepted command, and checks the command order.
   initial begin : mem_ctrl
      cmd_t c;
      forever begin
         @(negedge clock);
         if (reset) begin
            ret_q.delete();
            exp_cmd_q.delete();
            mem_accept_i = 1'b0;
            mem_valid_i  = 1'b0;
            mem_last_i   = 1'b0;
         end else begin
            mem_accept_i = accept_en;
            if (ret_q.size() > 0) begin
               mem_valid_i = 1'b1;
               mem_data_i  = ret_q[0].data;
               mem_last_i  = ret_q[0].last;
            end else begin
               mem_valid_i = 1'b0;
               mem_last_i  = 1'b0;
            end
         end
         #1;
         if (!reset) begin
            if (mem_valid_i) check("mem_ready_in_flight", mem_ready_o, 1);
            if (mem_fetch_o && mem_accept_i) begin
               acc_count++;
               check("fetch_expected", exp_cmd_q.size() != 0, 1);
               if (exp_cmd_q.size() != 0) begin
                  c = exp_cmd_q.pop_front();
                  check("mem_addr", mem_addr_o, c.addr);
                  check("mem_rdid", mem_rdid_o, c.id);
               end
               for (int k = 0; k < 4; k++)
                  ret_q.push_back('{data: beat_data(mem_addr_o, k), last: (k == 3)});
            end
            if (mem_valid_i && mem_ready_o) void'(ret_q.pop_front());
         end
      end
   end

   // R sink: compares every R handshake with the scoreboard and checks that
   // a stalled beat holds its data/ID/last.
   initial begin : r_sink
      beat_t            e;
      logic             held = 1'b0;
      logic [WIDTH-1:0] h_data;
      logic [IDW-1:0]   h_id;
      logic             h_last;
      forever begin
         @(negedge clock);
         axi_rready_i = rready_en;
         #1;
         if (reset) begin
            exp_r_q.delete();
            held = 1'b0;
         end else begin
            if (held) begin
               check("r_hold_valid", axi_rvalid_o, 1);
               check("r_hold_data", axi_rdata_o, h_data);
               check("r_hold_id", axi_rid_o, h_id);
               check("r_hold_last", axi_rlast_o, h_last);
            end
            held = 1'b0;
            if (axi_rvalid_o && axi_rready_i) begin
               check("r_beat_expected", exp_r_q.size() != 0, 1);
               if (exp_r_q.size() != 0) begin
                  e = exp_r_q.pop_front();
                  check("r_id", axi_rid_o, e.id);
                  check("r_data", axi_rdata_o, e.data);
                  check("r_last", axi_rlast_o, e.last);
                  check("r_resp", axi_rresp_o, 2'b00);
               end
               r_beats++;
            end else if (axi_rvalid_o) begin
               held   = 1'b1;
               h_data = axi_rdata_o;
               h_id   = axi_rid_o;
               h_last = axi_rlast_o;
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      while ((ar_pend.size() != 0 || exp_cmd_q.size() != 0 || exp_r_q.size() != 0) && n < budget) begin
         @(posedge clock);
         n++;
      end
      check({tag, "_drain"}, n < budget, 1);
      @(posedge clock);
      #1;
   endtask

   initial begin : main
      int b_ar, b_acc, b_r, n;

      // ---- reset state ----
      repeat (3) @(posedge clock);
      #1;
      check("rst_arready", axi_arready_o, 0);
      check("rst_rvalid", axi_rvalid_o, 0);
      check("rst_rlast", axi_rlast_o, 0);
      check("rst_rresp", axi_rresp_o, 2'b00);
      check("rst_fetch", mem_fetch_o, 0);
      check("rst_mem_ready", mem_ready_o, 0);
      reset = 1'b0;
      @(posedge clock);
      #1;
      check("arready_after_reset", axi_arready_o, 1);
      check("mem_ready_after_reset", mem_ready_o, 1);

      // ---- single read: addr 0x80, id 5 -> beats A0..A3 ----
      b_r = r_beats;
      ar_pend.push_back('{id: 4'd5, addr: 32'h80});
      wait_drain("single", 200);
      check("single_beats", r_beats - b_r, 4);

      // ---- back-to-back with accept stalled 10 cycles ----
      accept_en = 1'b0;
      b_r = r_beats; b_acc = acc_count;
      ar_pend.push_back('{id: 4'd1, addr: 32'h100});
      ar_pend.push_back('{id: 4'd2, addr: 32'h200});
      ar_pend.push_back('{id: 4'd3, addr: 32'h300});
      repeat (10) @(posedge clock);
      #1;
      check("b2b_no_accept", acc_count - b_acc, 0);
      check("b2b_fetch_held", mem_fetch_o, 1);
      check("b2b_head_addr", mem_addr_o, 32'h100);
      check("b2b_head_id", mem_rdid_o, 4'd1);
      accept_en = 1'b1;
      wait_drain("b2b", 400);
      check("b2b_beats", r_beats - b_r, 12);
      check("b2b_accepts", acc_count - b_acc, 3);

      // ---- R backpressure: at most two bursts reserved in an 8-beat buffer ----
      rready_en = 1'b0;
      b_r = r_beats; b_acc = acc_count; b_ar = ar_count;
      ar_pend.push_back('{id: 4'd4, addr: 32'h400});
      ar_pend.push_back('{id: 4'd5, addr: 32'h480});
      ar_pend.push_back('{id: 4'd6, addr: 32'h500});
      repeat (20) @(posedge clock);
      #1;
      check("bp_ar_taken", ar_count - b_ar, 3);
      check("bp_two_fetches", acc_count - b_acc, 2);
      check("bp_no_third_fetch", mem_fetch_o, 0);
      check("bp_no_r_beats", r_beats - b_r, 0);
      rready_en = 1'b1;
      wait_drain("bp", 400);
      check("bp_beats", r_beats - b_r, 12);
      check("bp_accepts", acc_count - b_acc, 3);

      // ---- simultaneous fetch-accept and R beat: credit 4 -> 7 ----
      rready_en = 1'b0;
      ar_pend.push_back('{id: 4'd7, addr: 32'h600});
      repeat (12) @(posedge clock);
      #1;
      accept_en = 1'b0;
      ar_pend.push_back('{id: 4'd8, addr: 32'h680});
      repeat (6) @(posedge clock);
      #1;
      check("credit_before", 64'(dut.credit), 4);
      check("credit_fetch_pending", mem_fetch_o, 1);
      check("credit_rvalid", axi_rvalid_o, 1);
      accept_en = 1'b1;
      rready_en = 1'b1;
      @(posedge clock);
      #1;
      check("credit_after", 64'(dut.credit), 7);
      wait_drain("credit", 400);
      check("credit_drained", 64'(dut.credit), 0);

      // ---- command FIFO full: 17 ARs, controller not accepting ----
      accept_en = 1'b0;
      b_r = r_beats; b_ar = ar_count;
      for (int i = 0; i < 17; i++)
         ar_pend.push_back('{id: 4'(i), addr: 32'h1000 + 32'(i) * 32'h80});
      repeat (40) @(posedge clock);
      #1;
      check("full_ar_taken", ar_count - b_ar, 16);
      check("full_arready_low", axi_arready_o, 0);
      accept_en = 1'b1;
      wait_drain("full", 3000);
      check("full_ar_all", ar_count - b_ar, 17);
      check("full_beats", r_beats - b_r, 68);

      // ---- reset after two R beats of a burst ----
      b_r = r_beats;
      ar_pend.push_back('{id: 4'd9, addr: 32'h2000});
      n = 0;
      while (r_beats - b_r < 2 && n < 200) begin
         @(posedge clock);
         n++;
      end
      check("mid_reset_two_beats", r_beats - b_r, 2);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("mid_reset_rvalid", axi_rvalid_o, 0);
      check("mid_reset_arready", axi_arready_o, 0);
      check("mid_reset_fetch", mem_fetch_o, 0);
      check("mid_reset_rlast", axi_rlast_o, 0);
      check("mid_reset_mem_ready", mem_ready_o, 0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      b_r = r_beats;
      ar_pend.push_back('{id: 4'd10, addr: 32'h3000});
      wait_drain("post_reset", 200);
      check("post_reset_beats", r_beats - b_r, 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_rd_path.md
Name: axi_rd_path

Overview:
- Read datapath of the AXI4-to-SDRAM interface.
- Accepts AXI4 read-address requests and queues them as fetch commands to the memory controller.
- Buffers returned read-data and replays it on the AXI4 R channel with the correct RID, RLAST and RRESP.
- Uses credit-based buffer reservation so the memory controller is never back-pressured mid-burst.

Parameters:
- ADDRS, 32, address width.
- WIDTH, 32, data width.
- AXI_ID_WIDTH, 4, AXI ID width.
- CTRL_FIFO_DEPTH, 16, depth of the command FIFO and of the in-flight ID (tag) FIFO; power of two.
- DATA_FIFO_DEPTH, 512, read-data buffer depth in beats; power of two, at least 8.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- axi_arvalid_i  in  1  AR valid
- axi_arready_o  out  1  AR ready
- axi_araddr_i  in  ADDRS  read address
- axi_arid_i  in  AXI_ID_WIDTH  read ID
- axi_arlen_i  in  8  burst length minus one
- axi_arburst_i  in  2  burst type
- axi_rvalid_o  out  1  R valid
- axi_rready_i  in  1  R ready
- axi_rlast_o  out  1  last beat of burst
- axi_rresp_o  out  2  response, always OKAY (2'b00)
- axi_rid_o  out  AXI_ID_WIDTH  ID of current burst
- axi_rdata_o  out  WIDTH  read data
- mem_fetch_o  out  1  read command valid to the memory controller
- mem_accept_i  in  1  controller accepts command
- mem_rdid_o  out  AXI_ID_WIDTH  command ID
- mem_addr_o  out  ADDRS  command address
- mem_valid_i  in  1  read-data beat valid from the controller
- mem_ready_o  out  1  read-data ready to the controller
- mem_last_i  in  1  last beat from the controller
- mem_data_i  in  WIDTH  read-data beat

Behaviour:
- Reset values: axi_arready_o=0, axi_rvalid_o=0, axi_rlast_o=0, axi_rresp_o=2'b00, mem_fetch_o=0, mem_ready_o=0. All FIFOs empty. Credit counter=0. Beat counter=0.
- Supported bursts: INCR, arlen=3 (4 beats, BURST_BEATS), address bits [6:0]=0. Any other arvalid request triggers a simulation-only $error/$fatal. No synthesized checking.
- AR channel:
  - axi_arready_o is registered. It is 1 in the cycle after the command FIFO has at least two free slots, or at least one free slot with no push this cycle.
  - Handshake when arvalid and arready; push {araddr, arid} into the command FIFO.
- Issue:
  - mem_fetch_o=1 when the command FIFO is non-empty, the tag FIFO is not full, and credit+4 <= DATA_FIFO_DEPTH.
  - mem_addr_o and mem_rdid_o come from the command-FIFO head.
  - On fetch&accept: pop the command FIFO, push the ID into the tag FIFO, credit += 4.
  - mem_fetch_o must not change command while asserted without accept.
- Credit counter: width $clog2(DATA_FIFO_DEPTH)+1. Each R handshake (rvalid&rready) subtracts 1. A simultaneous fetch-accept and R beat gives net +3. Never exceeds DATA_FIFO_DEPTH.
- Data in:
  - mem_ready_o=1 whenever out of reset and the data FIFO is not full.
  - Full while mem_valid_i=1 is a simulation fatal, because credit forbids it.
  - Beats enter the data FIFO on mem_valid_i&mem_ready_o.
- R channel:
  - axi_rvalid_o = data FIFO non-empty.
  - Latency: a beat accepted at cycle N is presented at cycle N+1.
  - axi_rid_o = tag-FIFO head.
  - 2-bit beat counter increments on each R handshake and wraps 3->0; axi_rlast_o=1 when the counter is 3.
  - On the rlast handshake, pop the tag FIFO.
  - rvalid may only be high when the tag FIFO is non-empty; otherwise simulation fatal.
  - Data/ID/last hold stable while rvalid&!rready.
- mem_last_i must coincide with beat counter 3 on entry (input-side counter); mismatch is a simulation fatal.
- Ordering: responses are returned in command-issue order. IDs are not reordered.
- Reset mid-burst: all state is dropped and outputs return to reset values next cycle. In-flight controller data is not recovered, so the controller is reset together with this block.

Decomposition:
- Shared package (ddr3 AXI constants): BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00, BURST_BEATS=4.
- Reuse the existing sync_fifo three times: command FIFO {addr,id}, tag FIFO {id}, data FIFO {data}.
- No new sub-module.

Test Plan:
- Single read: AR addr=0x80, id=5 -> mem_fetch_o with addr 0x80, rdid 5. Controller returns 4 beats 0xA0..0xA3 -> R beats 0xA0..0xA3, rid=5, rlast on the 4th only, rresp=00.
- Back-to-back: 3 ARs with ids 1,2,3 issued while the controller stalls accept for 10 cycles -> commands issued in order. R bursts return ids 1,2,3 in order, each with exactly 4 beats.
- R backpressure: rready low for 20 cycles with DATA_FIFO_DEPTH=8 -> at most 2 fetches outstanding, no third fetch until beats drain, mem_ready_o never drops while data is in flight, no data lost.
- Command FIFO full: 17 ARs with the controller never accepting -> arready deasserts after 16 accepted. After accepts resume, all 17 complete.
- Simultaneous fetch-accept and R handshake in the same cycle -> credit goes from 4 to 7.
- Reset asserted mid-burst (after 2 R beats) -> next cycle rvalid=0, arready=0, mem_fetch_o=0. A fresh AR after reset completes normally.
